// File: rtl/pipe_de_skid_reg.sv
// Decode/execute pipeline register with a two-entry skid buffer, registered o_ready and flush.
// Optional stall-cycle counter is built when PIPE_DE_STALL_CNT_EN is defined.
module pipe_de_skid_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned RN_W   = 5,
  parameter int unsigned ALUC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_ready,
  output logic              o_valid,
  input  logic              i_flush,
  input  logic              i_wreg,
  input  logic              i_m2reg,
  input  logic              i_wmem,
  input  logic              i_aluimm,
  input  logic              i_shift,
  input  logic              i_jal,
  output logic              o_wreg,
  output logic              o_m2reg,
  output logic              o_wmem,
  output logic              o_aluimm,
  output logic              o_shift,
  output logic              o_jal,
  input  logic [ALUC_W-1:0] i_aluc,
  output logic [ALUC_W-1:0] o_aluc,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [DATA_W-1:0] o_imm,
  input  logic [RN_W-1:0]   i_rn,
  input  logic [RN_W-1:0]   i_sa,
  output logic [RN_W-1:0]   o_rn,
  output logic [RN_W-1:0]   o_sa,
  input  logic [PC_W-1:0]   i_pc4,
  output logic [PC_W-1:0]   o_pc4,
  input  logic              i_cnt_clr,
  output logic [15:0]       o_stall_cnt
);

  localparam int unsigned PayW = 6 + ALUC_W + 3 * DATA_W + 2 * RN_W + PC_W;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e          state_q, state_d;
  logic            ready_q;
  logic [PayW-1:0] main_q, skid_q, in_pay;
  logic            load_main, load_skid, main_from_skid;
  logic            accept, drain, valid;
  logic            m_wreg, m_m2reg, m_wmem, m_jal;

  assign in_pay = {i_wreg, i_m2reg, i_wmem, i_aluimm, i_shift, i_jal,
                   i_aluc, i_a, i_b, i_imm, i_rn, i_sa, i_pc4};

  assign valid  = (state_q != StEmpty);
  assign accept = i_valid && ready_q;
  assign drain  = valid && i_ready;

  // State register; o_ready is a flop so no path exists from i_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != StTwo);
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d   = StOne;
          load_main = 1'b1;
        end
      end
      StOne: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = StTwo;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (drain) begin
          state_d        = StOne;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush kills everything held plus any same-cycle input.
    if (i_flush) begin
      state_d        = StEmpty;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= in_pay;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_pay;
      end
    end
  end

  assign {m_wreg, m_m2reg, m_wmem, o_aluimm, o_shift, m_jal,
          o_aluc, o_a, o_b, o_imm, o_rn, o_sa, o_pc4} = main_q;

  // Side-effecting controls read as a bubble whenever nothing valid is held.
  always_comb begin
    o_valid = valid;
    o_ready = ready_q;
    o_wreg  = m_wreg & valid;
    o_m2reg = m_m2reg & valid;
    o_wmem  = m_wmem & valid;
    o_jal   = m_jal & valid;
  end

`ifdef PIPE_DE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (i_cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (valid && !i_ready && !i_flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = i_cnt_clr;
  assign o_stall_cnt    = '0;
`endif

endmodule

// File: doc/pipe_de_skid_reg.md
PIPE_DE_SKID_REG -- requirements
Module: pipe_de_skid_reg

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
- DATA_W, 32, width of i_a/i_b/i_imm and o_a/o_b/o_imm.
- PC_W, 8, width of i_pc4/o_pc4.
- RN_W, 5, width of i_rn/o_rn and i_sa/o_sa.
- ALUC_W, 4, width of i_aluc/o_aluc.
REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, asynchronous, active-low reset.
- i_valid, in, 1, upstream (decode) holds a valid instruction.
- o_ready, out, 1, stage can accept this cycle.
- i_ready, in, 1, downstream (execute) accepts this cycle.
- o_valid, out, 1, o_* payload holds a valid instruction.
- i_flush, in, 1, synchronous kill of all held and incoming instructions.
- i_wreg/i_m2reg/i_wmem/i_aluimm/i_shift/i_jal, in, 1 each, control bits.
- o_wreg/o_m2reg/o_wmem/o_aluimm/o_shift/o_jal, out, 1 each, registered control bits.
- i_aluc, in, ALUC_W, ALU control; o_aluc, out, ALUC_W.
- i_a/i_b/i_imm, in, DATA_W, operands; o_a/o_b/o_imm, out, DATA_W.
- i_rn/i_sa, in, RN_W, dest register and shift amount; o_rn/o_sa, out, RN_W.
- i_pc4, in, PC_W, PC+4; o_pc4, out, PC_W.
- i_cnt_clr, in, 1, synchronous clear of stall counter.
- o_stall_cnt, out, 16, stall-cycle counter.

Function
REQ-003 Accept SHALL be i_valid && o_ready; drain SHALL be o_valid && i_ready.
REQ-004 Storage SHALL be two entries, main (drives o_*) and skid; state machine EMPTY, ONE, TWO.
REQ-005 EMPTY: accept -> ONE, main <= inputs; otherwise stay.
REQ-006 ONE: accept&&drain -> ONE, main <= inputs; accept&&!drain -> TWO, skid <= inputs; !accept&&drain -> EMPTY; neither -> ONE, main held.
REQ-007 TWO: drain -> ONE, main <= skid; !drain -> TWO, both held.
REQ-008 o_ready SHALL be registered, equal to (state != TWO), with no combinational path from i_ready.
REQ-009 o_valid SHALL be (state != EMPTY).
REQ-010 Latency SHALL be 1 cycle from accept in EMPTY to o_valid; sustained throughput SHALL be 1 instruction/cycle while i_ready=1.
REQ-011 Order SHALL be preserved; no instruction is duplicated or dropped except by flush.
REQ-012 i_flush=1 SHALL force next state EMPTY, discarding main, skid and any same-cycle input; flush overrides accept and drain.
REQ-013 While o_valid=0, o_wreg, o_m2reg, o_wmem and o_jal SHALL be 0 (bubble), and o_* data SHALL hold its last value.
REQ-014 Payload bits SHALL pass unmodified; no arithmetic is applied to payload.

Reset
REQ-015 rst=0 SHALL asynchronously force state EMPTY, o_ready=0, and all o_* payload, o_valid and o_stall_cnt to 0.
REQ-016 On the first rising clk edge after rst deasserts, o_ready SHALL become 1.
REQ-017 Reset asserted mid-operation SHALL discard both entries with no partial output.

Configuration
REQ-018 Macro PIPE_DE_STALL_CNT_EN defined: o_stall_cnt SHALL increment each cycle with o_valid && !i_ready && !i_flush, saturate at 16'hFFFF, and clear to 0 on i_cnt_clr=1 (clear wins over increment).
REQ-019 Macro PIPE_DE_STALL_CNT_EN undefined: o_stall_cnt SHALL be constant 0, i_cnt_clr SHALL be ignored, and no counter flops SHALL exist.

Verification
REQ-020 Stream: i_ready=1, i_valid=1 for 4 cycles, i_a=1,2,3,4 -> o_valid from cycle 1, o_a=1,2,3,4 on consecutive cycles, o_ready stays 1.
REQ-021 Backpressure: fill with i_a=10,11 while i_ready=0 -> state TWO, o_ready=0, o_a=10 held; i_ready=1 -> o_a=10 then 11, o_ready returns 1 after the first drain.
REQ-022 Flush: state TWO with o_wreg=1, i_flush=1 and i_valid=1 same cycle -> next cycle o_valid=0, o_wreg=0, o_wmem=0, o_ready=1.
REQ-023 Async reset: rst=0 between clock edges while o_valid=1, o_a=32'hDEADBEEF -> o_valid=0 and o_a=0 immediately, without waiting for an edge.
REQ-024 Counter (macro defined): o_valid=1, i_ready=0 for 5 cycles -> o_stall_cnt=5; i_cnt_clr=1 -> 0; preload to 16'hFFFF and stall -> stays 16'hFFFF.
REQ-025 Counter (macro undefined): the REQ-024 stimulus -> o_stall_cnt=0 throughout.
